vga_scanout: RTL

//  Read side of the VGA frame buffer. Generates 640x480@60 VGA timing from the system clock.

---
 rtl/vga_scanout.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout -- read side of the VGA frame buffer.
//
// Generates VGA timing (640x480@60 by default) from the system clock,
// fetches one RGB332 pixel per pixel period from the frame buffer read
// port, and shows the 256x240 buffer upscaled 2x in a 512x480 window
// centred horizontally. Active pixels outside the window show
// BORDER_COLOR. Colour is forced to zero whenever blank_n is low.
//
// Ports:
//   clk          system clock, also clocks the frame buffer read port
//   rst          synchronous active-high reset
//   mem_q        frame buffer read data, valid one clk after mem_addr
//   mem_addr     frame buffer read address {fb_y, fb_x} (registered)
//   vga_r/g/b    RGB332 colour to the pins (registered)
//   vga_hsync    horizontal sync, active low (registered)
//   vga_vsync    vertical sync, active low (registered)
//   vga_blank_n  1 while the pins carry active video (registered)
//   vblank       1 while the line counter is in vertical blanking
//                (counter timing, not pipeline-delayed)
//   frame_start  one-clk pulse when the counters wrap to (0,0)
module vga_scanout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int X_OFFSET   = 64,
  parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic                  vga_blank_n,
  output logic                  vblank,
  output logic                  frame_start
);

  localparam int CW = 10;
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  // Window is 2 x 256 frame-buffer columns wide.
  localparam logic [CW-1:0] WIN_BEG = CW'(X_OFFSET);
  localparam logic [CW-1:0] WIN_END = CW'(X_OFFSET + 512);

  // Colour for one output pixel: memory inside the window, border in the
  // rest of the active area, black during blanking.
  function automatic logic [DATA_WIDTH-1:0] pixel_sel(
    input logic                  win,
    input logic                  act,
    input logic [DATA_WIDTH-1:0] q
  );
    if (win)      return q;
    else if (act) return BORDER_COLOR;
    else          return '0;
  endfunction

  logic [DW-1:0]         div_q, div_d;
  logic [CW-1:0]         hcnt_q, hcnt_d;
  logic [CW-1:0]         vcnt_q, vcnt_d;
  logic                  fs_q, fs_d;
  logic                  pix_en;

  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d;
  logic                  act_p1_q, act_p1_d;
  logic                  win_p1_q, win_p1_d;
  logic                  hs_p1_q, hs_p1_d;
  logic                  vs_p1_q, vs_p1_d;

  logic [DATA_WIDTH-1:0] rgb_p2_q, rgb_p2_d;
  logic                  hsync_p2_q;
  logic                  vsync_p2_q;
  logic                  blank_n_p2_q;

  logic [CW-1:0]         hx;
  logic                  unused_hx;

  assign pix_en = (div_q == DIV_LAST);

  // ---- counter stage: pixel divider, hcnt/vcnt, frame wrap ----
  always_comb begin
    div_d  = pix_en ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fs_d   = 1'b0;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          fs_d   = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  // ---- stage p1: decode position, issue frame buffer address ----
  // Column offset inside the window; halving it gives fb_x (2x upscale).
  assign hx        = hcnt_q - WIN_BEG;
  assign unused_hx = ^{hx[CW-1], hx[0]};

  always_comb begin
    act_p1_d  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    win_p1_d  = act_p1_d && (hcnt_q >= WIN_BEG) && (hcnt_q < WIN_END);
    addr_p1_d = win_p1_d ? ADDR_WIDTH'({vcnt_q[8:1], hx[8:1]}) : '0;
    hs_p1_d   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_p1_d   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  end

  // ---- stage p2: mem_q has settled (CLK_DIV >= 2), pick colour ----
  always_comb begin
    rgb_p2_d = pixel_sel(win_p1_q, act_p1_q, mem_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      fs_q         <= 1'b0;
      addr_p1_q    <= '0;
      act_p1_q     <= 1'b0;
      win_p1_q     <= 1'b0;
      hs_p1_q      <= 1'b1;
      vs_p1_q      <= 1'b1;
      rgb_p2_q     <= '0;
      hsync_p2_q   <= 1'b1;
      vsync_p2_q   <= 1'b1;
      blank_n_p2_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fs_q   <= fs_d;
      if (pix_en) begin
        addr_p1_q    <= addr_p1_d;
        act_p1_q     <= act_p1_d;
        win_p1_q     <= win_p1_d;
        hs_p1_q      <= hs_p1_d;
        vs_p1_q      <= vs_p1_d;
        rgb_p2_q     <= rgb_p2_d;
        hsync_p2_q   <= hs_p1_q;
        vsync_p2_q   <= vs_p1_q;
        blank_n_p2_q <= act_p1_q;
      end
    end
  end

  assign mem_addr    = addr_p1_q;
  assign vga_r       = rgb_p2_q[7:5];
  assign vga_g       = rgb_p2_q[4:2];
  assign vga_b       = rgb_p2_q[1:0];
  assign vga_hsync   = hsync_p2_q;
  assign vga_vsync   = vsync_p2_q;
  assign vga_blank_n = blank_n_p2_q;
  assign vblank      = (vcnt_q >= V_ACT);
  assign frame_start = fs_q;

endmodule
